// File: rtl/adder_pkg.sv
// adder_pkg: shared state encoding and sizing helpers for the serial adder datapath
//
// Contents:
//   serial_state_t  IDLE / RUN / DONE encoding used by chunked_serial_adder
//   nchunk()        number of CHUNK-bit slices needed to cover WIDTH bits
//   cnt_width()     chunk counter width; one bit wider than strictly needed
//                   so that a count of NCHUNK-1 never wraps, even when NCHUNK is 1
package adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } serial_state_t;

    function automatic int nchunk(input int width, input int chunk);
        return width / chunk;
    endfunction

    function automatic int cnt_width(input int width, input int chunk);
        return $clog2(width / chunk) + 1;
    endfunction

endpackage

// File: rtl/ripple_chunk.sv
// ripple_chunk: combinational N-bit adder slice that also exposes the carry into its MSB
//
// Ports:
//   a, b  in  N  slice operands
//   cin   in  1  carry into bit 0
//   s     out N  slice sum
//   cout  out 1  carry out of bit N-1
//   cmsb  out 1  carry into bit N-1, used by the caller for signed overflow
module ripple_chunk #(
    parameter int N = 4
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] s,
    output logic         cout,
    output logic         cmsb
);

    // The carry into the top bit is recovered from the sum bit: s = a ^ b ^ c.
    always_comb begin
        {cout, s} = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};
        cmsb      = s[N-1] ^ a[N-1] ^ b[N-1];
    end

endmodule

// File: rtl/chunked_serial_adder.sv
// chunked_serial_adder: multi-cycle WIDTH-bit add/subtract, CHUNK bits per clock through one slice
//
// Ports:
//   Clk    in   1      rising-edge clock
//   Reset  in   1      asynchronous active-high reset
//   Start  in   1      request, accepted only in IDLE or DONE
//   Sub    in   1      0: A+B+Cin, 1: A-B (A + ~B + 1)
//   Cin    in   1      carry-in for add mode
//   A, B   in   WIDTH  operands, sampled on the accept edge
//   Sum    out  WIDTH  result, updated only on entry to DONE
//   CO     out  1      carry out of the MSB (0 means borrow in Sub mode)
//   V      out  1      signed overflow
//   Busy   out  1      high while the slice is iterating
//   Done   out  1      high while Sum/CO/V hold a fresh result
module chunked_serial_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic             Sub,
    input  logic             Cin,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Sum,
    output logic             CO,
    output logic             V,
    output logic             Busy,
    output logic             Done
);

    localparam int NCHUNK = nchunk(WIDTH, CHUNK);
    localparam int CW     = cnt_width(WIDTH, CHUNK);

    if (WIDTH % CHUNK != 0) begin : g_bad_chunk
        $error("chunked_serial_adder: WIDTH must be a multiple of CHUNK");
    end

    serial_state_t    state;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] sh;
    logic [WIDTH-1:0] sh_next;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic [CHUNK-1:0] s;
    logic             cout;
    logic             cmsb;
    logic             accept;
    logic             last;

    ripple_chunk #(.N(CHUNK)) u_slice (
        .a   (a_r[CHUNK-1:0]),
        .b   (b_r[CHUNK-1:0]),
        .cin (carry),
        .s   (s),
        .cout(cout),
        .cmsb(cmsb)
    );

    // Slice results enter at the MSB end; after NCHUNK steps the first slice sits at bit 0.
    assign sh_next = WIDTH'({s, sh} >> CHUNK);
    assign accept  = Start && (state != RUN);
    assign last    = cnt == CW'(NCHUNK - 1);
    assign Busy    = state == RUN;
    assign Done    = state == DONE;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
            a_r   <= '0;
            b_r   <= '0;
            sh    <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            Sum   <= '0;
            CO    <= 1'b0;
            V     <= 1'b0;
        end else if (accept) begin
            state <= RUN;
            a_r   <= A;
            b_r   <= Sub ? ~B : B;
            carry <= Sub | Cin;
            cnt   <= '0;
            sh    <= '0;
        end else if (state == RUN) begin
            a_r   <= a_r >> CHUNK;
            b_r   <= b_r >> CHUNK;
            sh    <= sh_next;
            carry <= cout;
            cnt   <= cnt + CW'(1);
            if (last) begin
                state <= DONE;
                Sum   <= sh_next;
                CO    <= cout;
                V     <= cout ^ cmsb;
            end
        end
    end

endmodule

// File: tb/tb_chunked_serial_adder.sv
// tb_chunked_serial_adder: directed and randomised self-checking bench for chunked_serial_adder
module tb_chunked_serial_adder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0, sub = 1'b0, cin = 1'b0;
    logic [15:0] a = '0, b = '0, sum;
    logic        co, v, busy, done;
    int          checks = 0;
    int          errors = 0;

    logic        sw_start = 1'b0, sw_sub = 1'b0, sw_cin = 1'b0;
    logic [31:0] sw_a = '0, sw_b = '0;
    logic [15:0] d1_sum, d16_sum;
    logic [31:0] d32_sum;
    logic        d1_co, d1_v, d1_busy, d1_done;
    logic        d16_co, d16_v, d16_busy, d16_done;
    logic        d32_co, d32_v, d32_busy, d32_done;

    always #5 clk = ~clk;

    chunked_serial_adder dut (
        .Clk(clk), .Reset(rst), .Start(start), .Sub(sub), .Cin(cin), .A(a), .B(b),
        .Sum(sum), .CO(co), .V(v), .Busy(busy), .Done(done)
    );

    chunked_serial_adder #(.WIDTH(16), .CHUNK(1)) d1 (
        .Clk(clk), .Reset(rst), .Start(sw_start), .Sub(sw_sub), .Cin(sw_cin), .A(sw_a[15:0]), .B(sw_b[15:0]),
        .Sum(d1_sum), .CO(d1_co), .V(d1_v), .Busy(d1_busy), .Done(d1_done)
    );

    chunked_serial_adder #(.WIDTH(16), .CHUNK(16)) d16 (
        .Clk(clk), .Reset(rst), .Start(sw_start), .Sub(sw_sub), .Cin(sw_cin), .A(sw_a[15:0]), .B(sw_b[15:0]),
        .Sum(d16_sum), .CO(d16_co), .V(d16_v), .Busy(d16_busy), .Done(d16_done)
    );

    chunked_serial_adder #(.WIDTH(32), .CHUNK(8)) d32 (
        .Clk(clk), .Reset(rst), .Start(sw_start), .Sub(sw_sub), .Cin(sw_cin), .A(sw_a), .B(sw_b),
        .Sum(d32_sum), .CO(d32_co), .V(d32_v), .Busy(d32_busy), .Done(d32_done)
    );

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Drives one request and waits (bounded) for Done; returns #1 after the completion edge.
    task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_v, input logic ts, input logic tc);
        @(negedge clk);
        a = ta; b = tb_v; sub = ts; cin = tc; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int i = 0; i < 10 && !done; i++) begin
            @(posedge clk); #1;
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL run_op_timeout done=%b want 1", done);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if ({sum, co, v, busy, done} !== 20'h0) begin
            errors++;
            $display("FAIL reset_main got sum=%h co=%b v=%b busy=%b done=%b want all 0", sum, co, v, busy, done);
        end
        checks++;
        if ({d1_busy, d1_done, d16_busy, d16_done, d32_busy, d32_done, d32_sum} !== 38'h0) begin
            errors++;
            $display("FAIL reset_sweep got d32_sum=%h flags=%b%b%b%b%b%b want 0", d32_sum,
                     d1_busy, d1_done, d16_busy, d16_done, d32_busy, d32_done);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        @(negedge clk);
        a = 16'h1234; b = 16'h4321; sub = 1'b0; cin = 1'b0; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (busy !== 1'b1 || done !== 1'b0 || sum !== 16'h0000) begin
                errors++;
                $display("FAIL basic_run t+%0d got busy=%b done=%b sum=%h want 1 0 0000", k, busy, done, sum);
            end
            @(posedge clk); #1;
        end
        checks++;
        if ({busy, done, sum, co, v} !== {1'b0, 1'b1, 16'h5555, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL basic_done got busy=%b done=%b sum=%h co=%b v=%b want 0 1 5555 0 0", busy, done, sum, co, v);
        end
    endtask

    task automatic test_add_carry();
        run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        checks++;
        if ({sum, co, v} !== {16'h0000, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL carry_ffff_1 got sum=%h co=%b v=%b want 0000 1 0", sum, co, v);
        end
        run_op(16'hFFFF, 16'h0000, 1'b0, 1'b1);
        checks++;
        if ({sum, co, v} !== {16'h0000, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL carry_cin got sum=%h co=%b v=%b want 0000 1 0", sum, co, v);
        end
    endtask

    task automatic test_overflow();
        run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        checks++;
        if ({sum, co, v} !== {16'h8000, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL ovf_pos got sum=%h co=%b v=%b want 8000 0 1", sum, co, v);
        end
        run_op(16'h8000, 16'h8000, 1'b0, 1'b0);
        checks++;
        if ({sum, co, v} !== {16'h0000, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL ovf_neg got sum=%h co=%b v=%b want 0000 1 1", sum, co, v);
        end
    endtask

    task automatic test_sub();
        run_op(16'h0005, 16'h0007, 1'b1, 1'b1);
        checks++;
        if ({sum, co, v} !== {16'hFFFE, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL sub_borrow got sum=%h co=%b v=%b want fffe 0 0", sum, co, v);
        end
        run_op(16'h8000, 16'h0001, 1'b1, 1'b0);
        checks++;
        if ({sum, co, v} !== {16'h7FFF, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL sub_ovf got sum=%h co=%b v=%b want 7fff 1 1", sum, co, v);
        end
    endtask

    task automatic test_ignore_start();
        @(negedge clk);
        a = 16'h9000; b = 16'h9000; sub = 1'b0; cin = 1'b0; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        a = 16'hAAAA; b = 16'hAAAA; sub = 1'b1; cin = 1'b1; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({done, sum, co, v} !== {1'b1, 16'h2000, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL ignore_start got done=%b sum=%h co=%b v=%b want 1 2000 1 1", done, sum, co, v);
        end
        @(posedge clk); #1;
        checks++;
        if ({done, busy, sum} !== {1'b1, 1'b0, 16'h2000}) begin
            errors++;
            $display("FAIL done_hold got done=%b busy=%b sum=%h want 1 0 2000", done, busy, sum);
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        a = 16'h1234; b = 16'h1111; sub = 1'b0; cin = 1'b0; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({sum, co, v, busy, done} !== 20'h0) begin
            errors++;
            $display("FAIL async_reset got sum=%h co=%b v=%b busy=%b done=%b want all 0", sum, co, v, busy, done);
        end
        @(negedge clk) rst = 1'b0;
        run_op(16'h0F0F, 16'h0101, 1'b0, 1'b1);
        checks++;
        if ({sum, co, v} !== {16'h1011, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL after_reset got sum=%h co=%b v=%b want 1011 0 0", sum, co, v);
        end
    endtask

    task automatic test_back_to_back();
        run_op(16'h0001, 16'h0002, 1'b0, 1'b0);
        a = 16'h00F0; b = 16'h000F; sub = 1'b1; cin = 1'b0; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        checks++;
        if ({busy, done, sum} !== {1'b1, 1'b0, 16'h0003}) begin
            errors++;
            $display("FAIL b2b_restart got busy=%b done=%b sum=%h want 1 0 0003", busy, done, sum);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({busy, done} !== 2'b10) begin
            errors++;
            $display("FAIL b2b_latency got busy=%b done=%b want 1 0", busy, done);
        end
        @(posedge clk); #1;
        checks++;
        if ({done, sum, co, v} !== {1'b1, 16'h00E1, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL b2b_result got done=%b sum=%h co=%b v=%b want 1 00e1 1 0", done, sum, co, v);
        end
    endtask

    task automatic test_sweep();
        logic [31:0] bb;
        logic        c0, v16, v32;
        logic [16:0] r16;
        logic [32:0] r32;
        int          l1, l16, l32;
        @(negedge clk);
        for (int n = 0; n < 1000; n++) begin
            sw_a = $urandom; sw_b = $urandom;
            sw_sub = 1'($urandom_range(0, 1)); sw_cin = 1'($urandom_range(0, 1));
            sw_start = 1'b1;
            bb  = sw_sub ? ~sw_b : sw_b;
            c0  = sw_sub | sw_cin;
            r16 = {1'b0, sw_a[15:0]} + {1'b0, bb[15:0]} + {16'd0, c0};
            r32 = {1'b0, sw_a} + {1'b0, bb} + {32'd0, c0};
            v16 = (sw_a[15] == bb[15]) && (r16[15] != sw_a[15]);
            v32 = (sw_a[31] == bb[31]) && (r32[31] != sw_a[31]);
            @(posedge clk); #1 sw_start = 1'b0;
            checks++;
            if ({d1_done, d16_done, d32_done} !== 3'b000) begin
                errors++;
                $display("FAIL sweep_restart n=%0d done=%b%b%b want 000", n, d1_done, d16_done, d32_done);
            end
            l1 = 0; l16 = 0; l32 = 0;
            for (int c = 1; c <= 20 && !(d1_done && d16_done && d32_done); c++) begin
                @(posedge clk); #1;
                if (d1_done && l1 == 0) l1 = c;
                if (d16_done && l16 == 0) l16 = c;
                if (d32_done && l32 == 0) l32 = c;
            end
            checks++;
            if (l1 != 16 || l16 != 1 || l32 != 4) begin
                errors++;
                $display("FAIL sweep_latency n=%0d got %0d/%0d/%0d want 16/1/4", n, l1, l16, l32);
            end
            checks++;
            if ({d1_co, d1_sum, d1_v} !== {r16, v16}) begin
                errors++;
                $display("FAIL sweep_c1 n=%0d got co=%b sum=%h v=%b want co=%b sum=%h v=%b",
                         n, d1_co, d1_sum, d1_v, r16[16], r16[15:0], v16);
            end
            checks++;
            if ({d16_co, d16_sum, d16_v} !== {r16, v16}) begin
                errors++;
                $display("FAIL sweep_c16 n=%0d got co=%b sum=%h v=%b want co=%b sum=%h v=%b",
                         n, d16_co, d16_sum, d16_v, r16[16], r16[15:0], v16);
            end
            checks++;
            if ({d32_co, d32_sum, d32_v} !== {r32, v32}) begin
                errors++;
                $display("FAIL sweep_w32 n=%0d got co=%b sum=%h v=%b want co=%b sum=%h v=%b",
                         n, d32_co, d32_sum, d32_v, r32[32], r32[31:0], v32);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_add_carry();
        test_overflow();
        test_sub();
        test_ignore_start();
        test_async_reset();
        test_back_to_back();
        test_sweep();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
